// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and the FSM state type for the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus output stream, bundled for the reader and its environment.
//
// Handshake: the stream word moves on every rising edge where m_valid and
// m_ready are both 1; while m_valid is 1 and m_ready is 0, m_data and m_last
// hold. fifo_next_read discards the FIFO head word on the same edge and is
// never raised while fifo_empty is 1.
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_next_read;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  // The reader: pops the FIFO and sources the stream.
  modport master (
    input  fifo_data, fifo_empty, m_ready,
    output fifo_next_read, m_data, m_valid, m_last
  );

  // The environment: FIFO plus downstream consumer.
  modport slave (
    output fifo_data, fifo_empty, m_ready,
    input  fifo_next_read, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Two-entry registered output stage (main + skid) keeping words in order.
// The main entry drives the outputs; the skid entry catches the single word
// that can be in flight when the consumer stalls. slot_free is the input ready:
// a word may be pushed only while the skid entry is empty.
module stream_skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             slot_free,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             out_fire;

  assign out_fire  = main_v_q & out_ready;
  assign slot_free = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  // Next-state: refill main from skid first, else from the input; park the input in skid when main is stuck.
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (out_fire) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (in_valid) begin
      if (!main_v_q || out_fire) begin
        main_d   = in_data;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_data;
        skid_v_d = 1'b1;
      end
    end else if (out_fire) begin
      main_v_d = 1'b0;
    end
  end

  // Storage registers; reset empties both entries and clears the visible data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO into a framed valid/ready stream: start + num_words launches a
// transfer, m_last tags its final word. The pop only looks at registered state
// and fifo_empty, so m_ready never reaches fifo_next_read combinationally.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state,
  fifo_stream_reader_if.master bus
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 slot_free;
  logic                 pop;
  logic                 pop_last;
  logic                 out_valid;
  logic [DATA_WIDTH:0]  out_word;

  // A pop needs a running transfer, a head word, words left to move and room in the skid entry.
  assign pop      = (state_q == S_RUN) & ~bus.fifo_empty &
                    (remaining_q != '0) & slot_free;
  assign pop_last = (remaining_q == CNT_WIDTH'(1));

  assign bus.fifo_next_read = pop;
  assign bus.m_valid        = out_valid;
  assign {bus.m_last, bus.m_data} = out_word;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  stream_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pop),
    .in_data   ({pop_last, bus.fifo_data}),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_ready (bus.m_ready),
    .out_data  (out_word)
  );

  // Next-state and word counter: count down on each pop, leave RUN on the last pop, finish on the last handshake.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_d     = S_RUN;
            remaining_d = num_words;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (pop) begin
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (pop_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last-tagged word is the youngest in the buffer, so its handshake empties it.
        if (out_valid && bus.m_ready && bus.m_last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small array-backed FIFO model
// and a negedge monitor logging pops and stream handshakes.
module tb_fifo_stream_reader
  import fifo_stream_reader_pkg::*;
;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic        busy, done;
  state_t      dbg_state;
  int          cyc = 0;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:63];
  int         rd_ptr = 0;
  int         wr_ptr = 0;

  assign bus.fifo_data  = mem[rd_ptr[5:0]];
  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_next_read && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  int         pop_cnt = 0;
  int         bad_pop = 0;
  int         pop_cyc_q[$];
  logic [8:0] got_q[$];
  int         got_cyc_q[$];
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_next_read) begin
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
        if (bus.fifo_empty) bad_pop++;
      end
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back({bus.m_last, bus.m_data});
        got_cyc_q.push_back(cyc);
      end
    end
  end

  int checks = 0;
  int passed = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_words = n;
    tick(1);
    start = 1'b0;
    num_words = 16'hBEEF;
  endtask

  // Returns the cycle in which done was seen high, or -1 after the budget runs out.
  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      tick(1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int p0, g0;
    bus.m_ready = 1'b0;
    tick(3);
    checks++; if ({busy, done, bus.m_valid, bus.m_last, bus.fifo_next_read} !== 5'b0)
      $display("FAIL reset_flags got=%05b exp=00000", {busy, done, bus.m_valid, bus.m_last, bus.fifo_next_read}); else passed++;
    checks++; if (bus.m_data !== 8'h00) $display("FAIL reset_data got=%0h exp=0", bus.m_data); else passed++;
    checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); else passed++;
    rst = 1'b0;
    tick(1);
    // Reset in the middle of a stalled transfer.
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    do_start(16'd4);
    tick(3);
    checks++; if (bus.m_valid !== 1'b1) $display("FAIL midxfer_valid got=%0b exp=1", bus.m_valid); else passed++;
    rst = 1'b1;
    tick(1);
    checks++; if ({busy, done, bus.m_valid, bus.m_last, bus.fifo_next_read} !== 5'b0)
      $display("FAIL midrst_flags got=%05b exp=00000", {busy, done, bus.m_valid, bus.m_last, bus.fifo_next_read}); else passed++;
    checks++; if (bus.m_data !== 8'h00) $display("FAIL midrst_data got=%0h exp=0", bus.m_data); else passed++;
    wr_ptr = rd_ptr;
    tick(1);
    rst = 1'b0;
    push_word(8'h55);
    push_word(8'h66);
    bus.m_ready = 1'b1;
    p0 = pop_cnt;
    g0 = got_q.size();
    tick(5);
    checks++; if (pop_cnt - p0 !== 0) $display("FAIL post_rst_pops got=%0d exp=0", pop_cnt - p0); else passed++;
    checks++; if (got_q.size() - g0 !== 0) $display("FAIL post_rst_words got=%0d exp=0", got_q.size() - g0); else passed++;
    checks++; if (bus.fifo_next_read !== 1'b0) $display("FAIL post_rst_next_read got=%0b exp=0", bus.fifo_next_read); else passed++;
    wr_ptr = rd_ptr;
    tick(1);
  endtask

  task automatic test_basic_transfer();
    int p0, g0, run_cyc, dc;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    bus.m_ready = 1'b1;
    p0 = pop_cyc_q.size();
    g0 = got_q.size();
    do_start(16'd4);
    run_cyc = cyc;
    checks++; if (dbg_state !== S_RUN || busy !== 1'b1)
      $display("FAIL basic_run got=%0d/%0b exp=%0d/1", dbg_state, busy, S_RUN); else passed++;
    wait_done(dc);
    checks++; if (pop_cyc_q.size() - p0 !== 4) $display("FAIL basic_pop_count got=%0d exp=4", pop_cyc_q.size() - p0);
    else begin
      passed++;
      checks++; if (pop_cyc_q[p0] !== run_cyc || pop_cyc_q[p0+3] !== run_cyc + 3)
        $display("FAIL basic_pop_timing got=%0d..%0d exp=%0d..%0d", pop_cyc_q[p0], pop_cyc_q[p0+3], run_cyc, run_cyc + 3); else passed++;
    end
    exp_q = {9'h001, 9'h002, 9'h003, 9'h104};
    checks++; if (got_q.size() - g0 !== 4) $display("FAIL basic_word_count got=%0d exp=4", got_q.size() - g0);
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[g0+i] !== exp_q[i]) $display("FAIL basic_word%0d got=%0h exp=%0h", i, got_q[g0+i], exp_q[i]); else passed++;
      end
      checks++; if (got_cyc_q[g0] !== run_cyc + 1) $display("FAIL basic_first_valid got=%0d exp=%0d", got_cyc_q[g0], run_cyc + 1); else passed++;
      checks++; if (dc !== got_cyc_q[g0+3] + 1) $display("FAIL basic_done_cycle got=%0d exp=%0d", dc, got_cyc_q[g0+3] + 1); else passed++;
    end
    tick(1);
    checks++; if (dbg_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL basic_back_idle got=%0d/%0b/%0b exp=%0d/0/0", dbg_state, busy, done, S_IDLE); else passed++;
  endtask

  // Partial transfer followed straight away by a second one at the first legal cycle.
  task automatic test_back_to_back();
    int p0, g0, dc;
    for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
    p0 = pop_cnt;
    g0 = got_q.size();
    do_start(16'd3);
    wait_done(dc);
    checks++; if (dc < 0) $display("FAIL partial_done_timeout got=%0d exp=done", dc); else passed++;
    checks++; if (pop_cnt - p0 !== 3) $display("FAIL partial_pops got=%0d exp=3", pop_cnt - p0); else passed++;
    checks++; if (wr_ptr - rd_ptr !== 2) $display("FAIL partial_left got=%0d exp=2", wr_ptr - rd_ptr); else passed++;
    checks++; if (bus.fifo_data !== 8'h13) $display("FAIL partial_head got=%0h exp=13", bus.fifo_data); else passed++;
    tick(1);
    do_start(16'd2);
    checks++; if (dbg_state !== S_RUN) $display("FAIL b2b_accept got=%0d exp=%0d", dbg_state, S_RUN); else passed++;
    wait_done(dc);
    exp_q = {9'h010, 9'h011, 9'h112, 9'h013, 9'h114};
    checks++; if (got_q.size() - g0 !== 5) $display("FAIL b2b_word_count got=%0d exp=5", got_q.size() - g0);
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_q[g0+i] !== exp_q[i]) $display("FAIL b2b_word%0d got=%0h exp=%0h", i, got_q[g0+i], exp_q[i]); else passed++;
      end
    end
    tick(1);
  endtask

  task automatic test_backpressure();
    int p0, g0, ps, dc, held_bad;
    logic [7:0] held;
    for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
    bus.m_ready = 1'b1;
    p0 = pop_cnt;
    g0 = got_q.size();
    do_start(16'd8);
    tick(2);
    bus.m_ready = 1'b0;
    ps = pop_cnt;
    held = bus.m_data;
    held_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.m_valid !== 1'b1 || bus.m_data !== held) held_bad++;
      tick(1);
    end
    checks++; if (held !== 8'h21) $display("FAIL bp_held_word got=%0h exp=21", held); else passed++;
    checks++; if (held_bad !== 0) $display("FAIL bp_hold got=%0d exp=0", held_bad); else passed++;
    checks++; if (pop_cnt - ps !== 1) $display("FAIL bp_extra_pops got=%0d exp=1", pop_cnt - ps); else passed++;
    checks++; if (bus.fifo_next_read !== 1'b0) $display("FAIL bp_next_read got=%0b exp=0", bus.fifo_next_read); else passed++;
    bus.m_ready = 1'b1;
    wait_done(dc);
    checks++; if (pop_cnt - p0 !== 8) $display("FAIL bp_total_pops got=%0d exp=8", pop_cnt - p0); else passed++;
    checks++; if (got_q.size() - g0 !== 8) $display("FAIL bp_word_count got=%0d exp=8", got_q.size() - g0);
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        checks++; if (got_q[g0+i] !== {(i == 7), 8'h20 + 8'(i)})
          $display("FAIL bp_word%0d got=%0h exp=%0h", i, got_q[g0+i], {(i == 7), 8'h20 + 8'(i)}); else passed++;
      end
    end
    tick(1);
  endtask

  task automatic test_empty_stall();
    int g0, ps, dc;
    push_word(8'h30);
    push_word(8'h31);
    bus.m_ready = 1'b1;
    g0 = got_q.size();
    do_start(16'd5);
    tick(4);
    ps = pop_cnt;
    tick(10);
    checks++; if (pop_cnt - ps !== 0) $display("FAIL stall_pops got=%0d exp=0", pop_cnt - ps); else passed++;
    checks++; if (bus.m_valid !== 1'b0) $display("FAIL stall_valid got=%0b exp=0", bus.m_valid); else passed++;
    checks++; if (dbg_state !== S_RUN) $display("FAIL stall_state got=%0d exp=%0d", dbg_state, S_RUN); else passed++;
    for (int i = 2; i < 5; i++) push_word(8'h30 + 8'(i));
    wait_done(dc);
    checks++; if (got_q.size() - g0 !== 5) $display("FAIL stall_word_count got=%0d exp=5", got_q.size() - g0);
    else begin
      passed++;
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_q[g0+i] !== {(i == 4), 8'h30 + 8'(i)})
          $display("FAIL stall_word%0d got=%0h exp=%0h", i, got_q[g0+i], {(i == 4), 8'h30 + 8'(i)}); else passed++;
      end
    end
    tick(1);
  endtask

  task automatic test_zero_and_ignore();
    int p0, g0, dc;
    for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
    bus.m_ready = 1'b1;
    p0 = pop_cnt;
    g0 = got_q.size();
    do_start(16'd0);
    checks++; if (done !== 1'b1 || dbg_state !== S_DONE)
      $display("FAIL zero_done got=%0b/%0d exp=1/%0d", done, dbg_state, S_DONE); else passed++;
    tick(1);
    checks++; if (done !== 1'b0 || dbg_state !== S_IDLE)
      $display("FAIL zero_idle got=%0b/%0d exp=0/%0d", done, dbg_state, S_IDLE); else passed++;
    checks++; if (pop_cnt - p0 !== 0 || got_q.size() - g0 !== 0)
      $display("FAIL zero_activity got=%0d/%0d exp=0/0", pop_cnt - p0, got_q.size() - g0); else passed++;
    bus.m_ready = 1'b0;
    do_start(16'd2);
    tick(2);
    do_start(16'd7);
    bus.m_ready = 1'b1;
    wait_done(dc);
    checks++; if (dc < 0) $display("FAIL ignore_done_timeout got=%0d exp=done", dc); else passed++;
    checks++; if (pop_cnt - p0 !== 2) $display("FAIL ignore_pops got=%0d exp=2", pop_cnt - p0); else passed++;
    checks++; if (wr_ptr - rd_ptr !== 3) $display("FAIL ignore_left got=%0d exp=3", wr_ptr - rd_ptr); else passed++;
    exp_q = {9'h040, 9'h141};
    checks++; if (got_q.size() - g0 !== 2) $display("FAIL ignore_word_count got=%0d exp=2", got_q.size() - g0);
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        checks++; if (got_q[g0+i] !== exp_q[i]) $display("FAIL ignore_word%0d got=%0h exp=%0h", i, got_q[g0+i], exp_q[i]); else passed++;
      end
    end
    tick(3);
    checks++; if (busy !== 1'b0 || pop_cnt - p0 !== 2)
      $display("FAIL ignore_settled got=%0b/%0d exp=0/2", busy, pop_cnt - p0); else passed++;
  endtask

  task automatic test_no_empty_pops();
    checks++; if (bad_pop !== 0) $display("FAIL pop_while_empty got=%0d exp=0", bad_pop); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_basic_transfer();
    test_back_to_back();
    test_backpressure();
    test_empty_stall();
    test_zero_and_ignore();
    test_no_empty_pops();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
